// File: rtl/sd_data_resp_receive.sv
// SD write-data response receiver: waits for the CRC status token on DAT0, decodes it, tracks card busy.
// Optional `SD_DATA_RESP_BUSY_COUNT_EN adds Busy_Cycles, the busy length latched when busy ends.
module sd_data_resp_receive #(
    parameter int unsigned START_TIMEOUT = 64,
    parameter int unsigned BUSY_TIMEOUT  = 1000000,
    parameter int unsigned BUSY_GUARD    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Resp_En,
    input  logic        DAT0,
    output logic        Resp_Complite,
    output logic [2:0]  Resp_Status,
    output logic        Resp_Accepted,
    output logic        Resp_Crc_Err,
    output logic        Resp_Write_Err,
    output logic        Resp_Frame_Err,
    output logic        Resp_Timeout,
    output logic        Busy
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
    ,
    output logic [23:0] Busy_Cycles
`endif
);

    // state        | meaning
    // S_IDLE       | waiting for Resp_En
    // S_WAIT_START | searching for the token start bit (DAT0=0)
    // S_STATUS     | shifting in the 3 status bits
    // S_END_BIT    | checking the end bit and decoding the status
    // S_BUSY       | card holds DAT0 low while programming
    // S_COMPLITE   | result held until Resp_En drops
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_STATUS,
        S_END_BIT,
        S_BUSY,
        S_COMPLITE
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(START_TIMEOUT - 1);
    localparam logic [23:0] BUSY_LAST = 24'(BUSY_TIMEOUT - 1);
    localparam logic [23:0] GUARD     = 24'(BUSY_GUARD);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [1:0]  bit_cnt;
    logic [23:0] busy_cnt;
    logic        abort;
    logic        tok_acc;
    logic        tok_crc;
    logic        tok_wr;

    assign abort   = !Resp_En && (state inside {S_WAIT_START, S_STATUS, S_END_BIT, S_BUSY});
    assign tok_acc = (Resp_Status == 3'b010);
    assign tok_crc = (Resp_Status == 3'b101);
    assign tok_wr  = (Resp_Status == 3'b110);

    // Updates on the falling edge so DAT0 is sampled mid-bit relative to the send stage.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            bit_cnt        <= '0;
            busy_cnt       <= '0;
            Resp_Complite  <= 1'b0;
            Resp_Status    <= '0;
            Resp_Accepted  <= 1'b0;
            Resp_Crc_Err   <= 1'b0;
            Resp_Write_Err <= 1'b0;
            Resp_Frame_Err <= 1'b0;
            Resp_Timeout   <= 1'b0;
            Busy           <= 1'b0;
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
            Busy_Cycles    <= '0;
`endif
        end else if (abort) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            bit_cnt        <= '0;
            busy_cnt       <= '0;
            Resp_Status    <= '0;
            Resp_Accepted  <= 1'b0;
            Resp_Crc_Err   <= 1'b0;
            Resp_Write_Err <= 1'b0;
            Resp_Frame_Err <= 1'b0;
            Resp_Timeout   <= 1'b0;
            Busy           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Resp_En) begin
                        wait_cnt       <= '0;
                        bit_cnt        <= '0;
                        busy_cnt       <= '0;
                        Resp_Complite  <= 1'b0;
                        Resp_Status    <= '0;
                        Resp_Accepted  <= 1'b0;
                        Resp_Crc_Err   <= 1'b0;
                        Resp_Write_Err <= 1'b0;
                        Resp_Frame_Err <= 1'b0;
                        Resp_Timeout   <= 1'b0;
                        Busy           <= 1'b0;
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
                        Busy_Cycles    <= '0;
`endif
                        state          <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (!DAT0) begin
                        bit_cnt <= '0;
                        state   <= S_STATUS;
                    end else if (wait_cnt == WAIT_LAST) begin
                        Resp_Timeout  <= 1'b1;
                        Resp_Complite <= 1'b1;
                        state         <= S_COMPLITE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_STATUS: begin
                    Resp_Status <= {Resp_Status[1:0], DAT0};
                    bit_cnt     <= bit_cnt + 2'd1;
                    if (bit_cnt == 2'd2) state <= S_END_BIT;
                end
                S_END_BIT: begin
                    Resp_Accepted  <= tok_acc && DAT0;
                    Resp_Crc_Err   <= tok_crc;
                    Resp_Write_Err <= tok_wr;
                    Resp_Frame_Err <= !(tok_acc || tok_crc || tok_wr) || !DAT0;
                    if (tok_acc && DAT0) begin
                        busy_cnt <= '0;
                        Busy     <= 1'b1;
                        state    <= S_BUSY;
                    end else begin
                        Resp_Complite <= 1'b1;
                        state         <= S_COMPLITE;
                    end
                end
                S_BUSY: begin
                    // Ready is tested before the timeout so a simultaneous release is not flagged.
                    if (DAT0 && (busy_cnt >= GUARD)) begin
                        Busy          <= 1'b0;
                        Resp_Complite <= 1'b1;
                        state         <= S_COMPLITE;
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
                        Busy_Cycles   <= busy_cnt;
`endif
                    end else if (busy_cnt == BUSY_LAST) begin
                        Busy          <= 1'b0;
                        Resp_Timeout  <= 1'b1;
                        Resp_Complite <= 1'b1;
                        state         <= S_COMPLITE;
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
                        Busy_Cycles   <= busy_cnt;
`endif
                    end else if (busy_cnt != 24'hFF_FFFF) begin
                        busy_cnt <= busy_cnt + 24'd1;
                    end
                end
                S_COMPLITE: begin
                    if (!Resp_En) begin
                        Resp_Complite <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_data_resp_receive.sv
// Bench for sd_data_resp_receive: directed and random DAT0 streams checked against a stream-level model.
module tb_sd_data_resp_receive;

    localparam int START_TO = 64;
    localparam int BUSY_TO  = 100;
    localparam int GUARD    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        Resp_En;
    logic        DAT0;
    logic        Resp_Complite;
    logic [2:0]  Resp_Status;
    logic        Resp_Accepted;
    logic        Resp_Crc_Err;
    logic        Resp_Write_Err;
    logic        Resp_Frame_Err;
    logic        Resp_Timeout;
    logic        Busy;
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
    logic [23:0] Busy_Cycles;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    logic q[$];

    typedef struct {
        logic [2:0] st;
        logic       acc;
        logic       crc;
        logic       wr;
        logic       frm;
        logic       tmo;
        int         done_idx;
        int         busy_obs;
        int         bcyc;
    } exp_t;

    sd_data_resp_receive #(
        .START_TIMEOUT(START_TO),
        .BUSY_TIMEOUT (BUSY_TO),
        .BUSY_GUARD   (GUARD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Resp_En       (Resp_En),
        .DAT0          (DAT0),
        .Resp_Complite (Resp_Complite),
        .Resp_Status   (Resp_Status),
        .Resp_Accepted (Resp_Accepted),
        .Resp_Crc_Err  (Resp_Crc_Err),
        .Resp_Write_Err(Resp_Write_Err),
        .Resp_Frame_Err(Resp_Frame_Err),
        .Resp_Timeout  (Resp_Timeout),
        .Busy          (Busy)
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
        ,
        .Busy_Cycles   (Busy_Cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] flags();
        return {Resp_Status, Resp_Accepted, Resp_Crc_Err, Resp_Write_Err, Resp_Frame_Err, Resp_Timeout};
    endfunction

    // Released bus reads high, so anything past the end of a stream is a 1.
    function automatic logic bit_at(input logic b[$], input int i);
        return (i < b.size()) ? b[i] : 1'b1;
    endfunction

    // Index i is the DAT0 value seen on the i-th sample after the start request.
    function automatic exp_t model(input logic b[$]);
        exp_t e;
        int   s;
        logic endb;
        e = '{st: 3'b000, acc: 1'b0, crc: 1'b0, wr: 1'b0, frm: 1'b0, tmo: 1'b0,
              done_idx: 0, busy_obs: 0, bcyc: 0};
        s = -1;
        for (int i = 0; i < START_TO; i++)
            if (s < 0 && bit_at(b, i) == 1'b0) s = i;
        if (s < 0) begin
            e.tmo      = 1'b1;
            e.done_idx = START_TO - 1;
            return e;
        end
        e.st       = {bit_at(b, s + 1), bit_at(b, s + 2), bit_at(b, s + 3)};
        endb       = bit_at(b, s + 4);
        e.crc      = (e.st == 3'b101);
        e.wr       = (e.st == 3'b110);
        e.acc      = (e.st == 3'b010) && endb;
        e.frm      = !(e.st inside {3'b010, 3'b101, 3'b110}) || !endb;
        e.done_idx = s + 4;
        if (e.acc) begin
            for (int k = 0; k < BUSY_TO; k++) begin
                if (k >= GUARD && bit_at(b, s + 5 + k)) begin
                    e.done_idx = s + 5 + k;
                    e.bcyc     = k;
                    break;
                end
                if (k == BUSY_TO - 1) begin
                    e.tmo      = 1'b1;
                    e.done_idx = s + 5 + k;
                    e.bcyc     = k;
                end
            end
            e.busy_obs = e.bcyc + 1;
        end
        return e;
    endfunction

    task automatic push(input logic v, input int n);
        for (int i = 0; i < n; i++) q.push_back(v);
    endtask

    task automatic push_tok(input logic [2:0] st, input logic endb);
        q.push_back(1'b0);
        q.push_back(st[2]);
        q.push_back(st[1]);
        q.push_back(st[0]);
        q.push_back(endb);
    endtask

    task automatic run(input string name, input logic b[$], input int abort_at, input int rst_at);
        exp_t e;
        int   done;
        int   busy_obs;
        e        = model(b);
        done     = -1;
        busy_obs = 0;
        @(posedge clk);
        Resp_En = 1'b1;
        DAT0    = 1'b1;
        @(negedge clk);
        #1;
        check({name, ":start_clear"}, 32'({Resp_Complite, Busy, flags()}), 32'h0);
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
        check({name, ":bc_clear"}, 32'(Busy_Cycles), 32'h0);
`endif
        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            DAT0 = bit_at(b, i);
            if (i == abort_at) Resp_En = 1'b0;
            if (i == rst_at) begin
                check({name, ":busy_before_rst"}, 32'(Busy), 32'h1);
                #2 rst = 1'b0;
                #1;
                check({name, ":rst_async"}, 32'({Resp_Complite, Busy, flags()}), 32'h0);
                rst     = 1'b1;
                Resp_En = 1'b0;
                DAT0    = 1'b1;
                return;
            end
            @(negedge clk);
            #1;
            if (Busy) busy_obs++;
            if (Resp_Complite) begin
                done = i;
                break;
            end
            if (abort_at >= 0 && i >= abort_at + 4) break;
        end
        if (abort_at < 0) begin
            check({name, ":done_idx"}, 32'(done), 32'(e.done_idx));
            check({name, ":flags"}, 32'(flags()), 32'({e.st, e.acc, e.crc, e.wr, e.frm, e.tmo}));
            check({name, ":busy_len"}, 32'(busy_obs), 32'(e.busy_obs));
            check({name, ":busy_low_at_done"}, 32'(Busy), 32'h0);
`ifdef SD_DATA_RESP_BUSY_COUNT_EN
            check({name, ":busy_cycles"}, 32'(Busy_Cycles), 32'(e.bcyc));
`endif
            @(posedge clk);
            Resp_En = 1'b0;
            DAT0    = 1'b1;
            @(negedge clk);
            #1;
            check({name, ":cpl_drop"}, 32'(Resp_Complite), 32'h0);
            check({name, ":flags_hold"}, 32'(flags()), 32'({e.st, e.acc, e.crc, e.wr, e.frm, e.tmo}));
        end else begin
            check({name, ":abort_no_cpl"}, 32'(done), 32'hFFFF_FFFF);
            check({name, ":abort_clear"}, 32'({Busy, flags()}), 32'h0);
        end
    endtask

    initial begin
        rst     = 1'b0;
        Resp_En = 1'b0;
        DAT0    = 1'b1;
        #12;
        check("reset", 32'({Resp_Complite, Busy, flags()}), 32'h0);
        rst = 1'b1;

        q.delete(); push(1'b1, 3); push_tok(3'b010, 1'b1); push(1'b0, 10); push(1'b1, 3);
        run("accept", q, -1, -1);
        check("accept_status", 32'(Resp_Status), 32'h2);

        q.delete(); push_tok(3'b101, 1'b1); push(1'b1, 2);
        run("crc_err", q, -1, -1);
        q.delete(); push_tok(3'b110, 1'b1); push(1'b1, 2);
        run("write_err", q, -1, -1);
        q.delete(); push_tok(3'b010, 1'b0); push(1'b0, 4);
        run("bad_end", q, -1, -1);
        q.delete(); push(1'b1, 2); push_tok(3'b011, 1'b1);
        run("bad_status", q, -1, -1);

        q.delete();
        run("start_timeout", q, -1, -1);
        check("start_timeout_flag", 32'(Resp_Timeout), 32'h1);
        q.delete(); push_tok(3'b010, 1'b1); push(1'b0, 150);
        run("busy_timeout", q, -1, -1);
        check("busy_timeout_acc", 32'({Resp_Accepted, Resp_Timeout}), 32'h3);
        q.delete(); push_tok(3'b010, 1'b1); push(1'b0, BUSY_TO - 1); push(1'b1, 2);
        run("ready_vs_timeout", q, -1, -1);
        q.delete(); push_tok(3'b010, 1'b1); push(1'b1, 2); push(1'b0, 3); push(1'b1, 2);
        run("guard_ignored", q, -1, -1);
        q.delete(); push_tok(3'b010, 1'b1); push(1'b1, 4);
        run("guard_min", q, -1, -1);

        q.delete(); push(1'b1, 2); push_tok(3'b010, 1'b1); push(1'b0, 5);
        run("abort_status", q, 3, -1);
        q.delete(); push_tok(3'b010, 1'b1); push(1'b0, 20);
        run("abort_busy", q, 11, -1);
        q.delete(); push(1'b1, 1); push_tok(3'b010, 1'b1); push(1'b0, 30);
        run("rst_busy", q, -1, 16);

        q.delete(); push_tok(3'b010, 1'b1); push(1'b0, 37); push(1'b1, 2);
        run("busy37", q, -1, -1);
        q.delete(); push_tok(3'b101, 1'b1);
        run("after_busy37", q, -1, -1);

        for (int t = 0; t < 24; t++) begin
            logic [2:0] st;
            q.delete();
            push(1'b1, ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(0, 12));
            st = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'(st_rand());
            push_tok(st, ($urandom_range(0, 6) != 0));
            push(1'($urandom_range(0, 1)), 1);
            push(1'($urandom_range(0, 1)), 1);
            push(1'b0, ($urandom_range(0, 7) == 0) ? 120 : $urandom_range(0, 60));
            push(1'b1, 2);
            run($sformatf("rand%0d", t), q, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    function automatic int unsigned st_rand();
        return $urandom_range(0, 7);
    endfunction

endmodule
